hs_fifo_bridge: RTL and testbench



---
 rtl/hs_fifo_bridge.sv | 121 ++++++++++++
 tb/tb_hs_fifo_bridge.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/hs_fifo_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : hs_fifo_bridge
//  Brief    : Elastic req/ack buffer between a dataflow graph output port and
//             its consumer. Pulls words upstream like a consumer and serves
//             them downstream like a producer. Holds up to DEPTH words in
//             order and exposes occupancy and transfer counters.
//  Revision : 1.0 - initial release
// ============================================================================
module hs_fifo_bridge #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  rst,        // synchronous, active-low
    output logic                  up_req,
    input  logic                  up_ack,
    input  logic [DATA_WIDTH-1:0] up_din,
    input  logic                  dn_req,
    output logic                  dn_ack,
    output logic [DATA_WIDTH-1:0] dn_dout,
    output logic [ADDR_WIDTH:0]   occupancy,
    output logic                  empty,
    output logic                  full,
    output logic                  overflow,
    output logic [31:0]           count_in,
    output logic [31:0]           count_out
);

    localparam logic [ADDR_WIDTH:0]   c_DEPTH   = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   c_OCC_ONE = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] c_PTR_ONE = ADDR_WIDTH'(1);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] wp_q, rp_q;
    logic [ADDR_WIDTH:0]   occ_q, occ_d;
    logic                  up_req_q, up_req_d;
    logic                  dn_ack_q;
    logic [DATA_WIDTH-1:0] dn_dout_q;
    logic                  empty_q, full_q, overflow_q;
    logic [31:0]           count_in_q, count_out_q;

    logic w_push;
    logic w_pop;
    logic w_drop;

    // A word is taken only when there is room; a pop needs a stored word and
    // is spaced by the previous ack so each delivery is a single-cycle pulse.
    assign w_push = up_ack & ~full_q;
    assign w_drop = up_ack & full_q;
    assign w_pop  = dn_req & ~dn_ack_q & ~empty_q;

    // Next occupancy after this edge's push and pop, and the upstream request
    // that follows from it (dropped for one cycle after every ack).
    always_comb begin
        occ_d    = occ_q;
        up_req_d = 1'b0;
        if (w_push && !w_pop) begin
            occ_d = occ_q + c_OCC_ONE;
        end else if (!w_push && w_pop) begin
            occ_d = occ_q - c_OCC_ONE;
        end
        up_req_d = ~up_ack & (occ_d < c_DEPTH);
    end

    // Storage array write; contents need no reset since pointers gate reads.
    always_ff @(posedge clk) begin
        if (rst && w_push) begin
            mem_q[wp_q] <= up_din;
        end
    end

    // Control, pointers, flags and counters. The pop reads the old head, so
    // data pushed on the same edge never reaches dn_dout directly.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wp_q        <= '0;
            rp_q        <= '0;
            occ_q       <= '0;
            up_req_q    <= 1'b0;
            dn_ack_q    <= 1'b0;
            dn_dout_q   <= '0;
            empty_q     <= 1'b1;
            full_q      <= 1'b0;
            overflow_q  <= 1'b0;
            count_in_q  <= '0;
            count_out_q <= '0;
        end else begin
            occ_q    <= occ_d;
            empty_q  <= (occ_d == '0);
            full_q   <= (occ_d == c_DEPTH);
            up_req_q <= up_req_d;
            dn_ack_q <= w_pop;
            if (w_push) begin
                wp_q       <= wp_q + c_PTR_ONE;
                count_in_q <= count_in_q + 32'd1;
            end
            if (w_drop) begin
                overflow_q <= 1'b1;
            end
            if (w_pop) begin
                dn_dout_q   <= mem_q[rp_q];
                rp_q        <= rp_q + c_PTR_ONE;
                count_out_q <= count_out_q + 32'd1;
            end
        end
    end

    assign up_req    = up_req_q;
    assign dn_ack    = dn_ack_q;
    assign dn_dout   = dn_dout_q;
    assign occupancy = occ_q;
    assign empty     = empty_q;
    assign full      = full_q;
    assign overflow  = overflow_q;
    assign count_in  = count_in_q;
    assign count_out = count_out_q;

endmodule
`default_nettype wire

// File: tb/tb_hs_fifo_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hs_fifo_bridge
//  Brief    : Self-checking bench for hs_fifo_bridge. A cycle model tracks the
//             expected flags and counters; accepted words go into a queue and
//             are compared against dn_dout when the DUT acks downstream.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_hs_fifo_bridge;

    localparam int DW  = 32;
    localparam int DEP = 8;
    localparam int AW  = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          up_req;
    logic          up_ack;
    logic [DW-1:0] up_din;
    logic          dn_req;
    logic          dn_ack;
    logic [DW-1:0] dn_dout;
    logic [AW:0]   occupancy;
    logic          empty, full, overflow;
    logic [31:0]   count_in, count_out;

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    logic [31:0] q[$];
    bit          m_dnack, m_upreq, m_ovf;
    logic [31:0] m_dout, m_cin, m_cout;
    int          cyc = 0;

    // stimulus control
    int          prod_left = 0;
    logic [31:0] prod_val  = 0;
    int          cons_mode = 0;   // 0 idle, 1 always request, 2 random stall

    always #5 clk = ~clk;

    hs_fifo_bridge #(.DATA_WIDTH(DW), .DEPTH(DEP), .ADDR_WIDTH(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .up_req    (up_req),
        .up_ack    (up_ack),
        .up_din    (up_din),
        .dn_req    (dn_req),
        .dn_ack    (dn_ack),
        .dn_dout   (dn_dout),
        .occupancy (occupancy),
        .empty     (empty),
        .full      (full),
        .overflow  (overflow),
        .count_in  (count_in),
        .count_out (count_out)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s @cycle %0d: got %0h, expected %0h", tag, cyc, obs, exp);
        end
    endtask

    // Advance one clock edge, update the model from the inputs sampled at that
    // edge, then compare every DUT output 1 time unit later.
    task automatic cycle();
        bit do_push, do_pop;
        @(posedge clk);
        cyc++;
        if (!rst) begin
            q.delete();
            m_dnack = 0; m_upreq = 0; m_ovf = 0;
            m_dout = 0; m_cin = 0; m_cout = 0;
        end else begin
            do_push = up_ack && (q.size() < DEP);
            do_pop  = dn_req && !m_dnack && (q.size() > 0);
            if (do_pop) begin
                m_dout = q.pop_front();
                m_cout = m_cout + 1;
            end
            if (do_push) begin
                q.push_back(up_din);
                m_cin = m_cin + 1;
            end
            if (up_ack && !do_push) m_ovf = 1;
            m_dnack = do_pop;
            m_upreq = !up_ack && (q.size() < DEP);
        end
        #1;
        check("occupancy", 32'(occupancy), q.size());
        check("empty", 32'(empty), 32'(q.size() == 0));
        check("full", 32'(full), 32'(q.size() == DEP));
        check("up_req", 32'(up_req), 32'(m_upreq));
        check("dn_ack", 32'(dn_ack), 32'(m_dnack));
        check("dn_dout", dn_dout, m_dout);
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("count_in", count_in, m_cin);
        check("count_out", count_out, m_cout);
        check("balance", count_in - count_out, 32'(occupancy));
        check("occ_bound", 32'(occupancy <= DEP), 32'd1);
    endtask

    // Producer answers an observed up_req with a one-cycle ack; consumer
    // requests according to cons_mode.
    task automatic auto_step();
        if (prod_left > 0 && up_req === 1'b1 && !up_ack) begin
            up_ack = 1'b1;
            up_din = prod_val;
            prod_val = prod_val + 1;
            prod_left--;
        end else begin
            up_ack = 1'b0;
        end
        case (cons_mode)
            1:       dn_req = 1'b1;
            2:       dn_req = ($urandom_range(0, 99) >= 30);
            default: dn_req = 1'b0;
        endcase
        cycle();
    endtask

    task automatic push_word(input logic [31:0] v);
        up_ack = 1'b1; up_din = v; dn_req = 1'b0;
        cycle();
        up_ack = 1'b0;
        cycle();
    endtask

    task automatic pop_word();
        up_ack = 1'b0; dn_req = 1'b1;
        cycle();
        dn_req = 1'b0;
        cycle();
    endtask

    task automatic push_pop(input logic [31:0] v);
        up_ack = 1'b1; up_din = v; dn_req = 1'b1;
        cycle();
        up_ack = 1'b0; dn_req = 1'b0;
        check("sim_occ", 32'(occupancy), 32'd4);
        cycle();
    endtask

    initial begin
        int last_ack;
        int npop;
        int guard;
        logic [31:0] saved_cin;

        // 1. reset with handshake inputs forced active
        rst = 1'b0; up_ack = 1'b1; up_din = 32'hFFFF_FFFF; dn_req = 1'b1;
        repeat (3) cycle();
        check("rst_count_in", count_in, 32'd0);
        check("rst_up_req", 32'(up_req), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);

        // 2. fill with consumer idle
        rst = 1'b1; up_ack = 1'b0; dn_req = 1'b0;
        prod_val = 0; prod_left = 100; cons_mode = 0;
        repeat (40) auto_step();
        check("fill_full", 32'(full), 32'd1);
        check("fill_occ", 32'(occupancy), 32'd8);
        check("fill_count_in", count_in, 32'd8);
        check("fill_overflow", 32'(overflow), 32'd0);

        // 3. drain with consumer always requesting
        prod_left = 0; cons_mode = 1; last_ack = -1; npop = 0; guard = 0;
        while (npop < 8 && guard < 60) begin
            auto_step();
            guard++;
            if (dn_ack === 1'b1) begin
                if (last_ack >= 0) check("drain_gap", 32'(cyc - last_ack), 32'd2);
                last_ack = cyc;
                npop++;
            end
        end
        check("drain_pops", 32'(npop), 32'd8);
        check("drain_empty", 32'(empty), 32'd1);
        check("drain_count_out", count_out, 32'd8);

        // 4. streaming 200 words with a randomly stalling consumer
        rst = 1'b0; up_ack = 1'b0; dn_req = 1'b0;
        cycle();
        rst = 1'b1;
        prod_val = 0; prod_left = 200; cons_mode = 2; guard = 0;
        while (!(prod_left == 0 && m_cout == 200) && guard < 4000) begin
            auto_step();
            guard++;
        end
        check("stream_done", m_cout, 32'd200);
        check("stream_count_out", count_out, 32'd200);
        check("stream_overflow", 32'(overflow), 32'd0);
        check("stream_sb_empty", 32'(q.size()), 32'd0);
        cons_mode = 0; up_ack = 1'b0; dn_req = 1'b0;
        cycle();

        // 5. simultaneous push/pop at occupancy 4, covering both pointer wraps
        for (int i = 0; i < 7; i++) push_word(32'd300 + 32'(i));
        repeat (3) pop_word();
        check("pre_sim_occ", 32'(occupancy), 32'd4);
        for (int i = 0; i < 5; i++) push_pop(32'd310 + 32'(i));
        repeat (4) pop_word();
        check("sim_drain_empty", 32'(empty), 32'd1);

        // 6. overflow, then reset while partially full
        for (int i = 0; i < 8; i++) push_word(32'd400 + 32'(i));
        check("ovf_pre_full", 32'(full), 32'd1);
        saved_cin = count_in;
        push_word(32'hDEAD);
        check("ovf_set", 32'(overflow), 32'd1);
        check("ovf_count_in", count_in, saved_cin);
        repeat (3) cycle();
        check("ovf_sticky", 32'(overflow), 32'd1);
        repeat (3) pop_word();
        check("pre_rst_occ", 32'(occupancy), 32'd5);
        rst = 1'b0; dn_req = 1'b1;
        cycle();
        rst = 1'b1;
        check("mid_rst_empty", 32'(empty), 32'd1);
        check("mid_rst_overflow", 32'(overflow), 32'd0);
        cycle();
        check("mid_rst_dn_ack", 32'(dn_ack), 32'd0);
        dn_req = 1'b0;
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
